// File: rtl/d_latch_pkg.sv
// rtl/d_latch_pkg.sv - shared constants and mode enum for the d_latch block
package d_latch_pkg;

  localparam int D_LATCH_DEFAULT_WIDTH = 1;
  localparam int D_LATCH_MAX_WIDTH     = 64;

  // Readable names for the two meanings of en.
  typedef enum logic {
    HOLD        = 1'b0,
    TRANSPARENT = 1'b1
  } mode_e;

endpackage

// File: rtl/d_latch_sync2.sv
// rtl/d_latch_sync2.sv - parameterized-width 2-flop synchronizer with reset value
module d_latch_sync2
  import d_latch_pkg::*;
#(
  parameter int               WIDTH   = D_LATCH_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; second stage gives it a cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      dout <= RST_VAL;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/d_latch.sv
// rtl/d_latch.sv - clocked gated-D-latch emulation with q, qbar and change pulse; option D_LATCH_SYNC_EN
module d_latch
  import d_latch_pkg::*;
#(
  parameter int               WIDTH   = D_LATCH_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             q_changed
);

  logic             en_s;
  logic [WIDTH-1:0] d_s;

`ifdef D_LATCH_SYNC_EN
  // Inputs may be asynchronous to clk: bring both through two flops first.
  d_latch_sync2 #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_sync_en (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (en),
    .dout  (en_s)
  );

  d_latch_sync2 #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_sync_d (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (d),
    .dout  (d_s)
  );
`else
  assign en_s = en;
  assign d_s  = d;
`endif

  // Capture d while transparent; qbar is a register of its own so that it
  // never glitches relative to q, and the pulse flags a real value change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= RST_VAL;
      qbar      <= ~RST_VAL;
      q_changed <= 1'b0;
    end else if (mode_e'(en_s) == TRANSPARENT) begin
      q         <= d_s;
      qbar      <= ~d_s;
      q_changed <= (d_s != q);
    end else begin
      q_changed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_d_latch.sv
// tb/tb_d_latch.sv - scoreboard bench for d_latch (1-bit and 8-bit instances)
module tb_d_latch;

  localparam logic [7:0] RV8 = 8'hA5;
`ifdef D_LATCH_SYNC_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       d1, en1, en8;
  logic [7:0] d8;
  logic       q1, qb1, c1, c8;
  logic [7:0] q8, qb8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  d_latch #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .d(d1), .en(en1),
    .q(q1), .qbar(qb1), .q_changed(c1)
  );

  d_latch #(.WIDTH(8), .RST_VAL(RV8)) dut8 (
    .clk(clk), .rst_n(rst_n), .d(d8), .en(en8),
    .q(q8), .qbar(qb8), .q_changed(c8)
  );

  typedef struct packed {
    logic       q1;
    logic       c1;
    logic [7:0] q8;
    logic       c8;
  } exp_t;

  typedef struct packed {
    logic       en;
    logic [7:0] d;
  } in_t;

  exp_t sb[$];
  in_t  h1[$];
  in_t  h8[$];
  logic       mq1;
  logic [7:0] mq8;

  function automatic exp_t reset_exp();
    exp_t e;
    e.q1 = 1'b0; e.c1 = 1'b0; e.q8 = RV8; e.c8 = 1'b0;
    return e;
  endfunction

  // Reference: outputs hold a value, inputs reach it after STAGES cycles of delay.
  function automatic void model_reset();
    mq1 = 1'b0;
    mq8 = RV8;
    h1.delete();
    h8.delete();
    for (int i = 0; i < STAGES; i++) begin
      h1.push_back(in_t'{en: 1'b0, d: 8'h00});
      h8.push_back(in_t'{en: 1'b0, d: RV8});
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Asynchronous reset forces outputs before the next edge: rewrite what is pending.
  always @(negedge rst_n) begin
    model_reset();
    if (sb.size() > 0) sb[$] = reset_exp();
  end

  // Reference model step at every rising edge, expected result queued.
  always @(posedge clk) begin
    exp_t e;
    in_t  x1, x8;
    if (!rst_n) begin
      model_reset();
      e = reset_exp();
    end else begin
      h1.push_back(in_t'{en: en1, d: {7'b0, d1}});
      h8.push_back(in_t'{en: en8, d: d8});
      x1 = h1.pop_front();
      x8 = h8.pop_front();
      e.c1 = x1.en && (x1.d[0] != mq1);
      e.c8 = x8.en && (x8.d != mq8);
      if (x1.en) mq1 = x1.d[0];
      if (x8.en) mq8 = x8.d;
      e.q1 = mq1;
      e.q8 = mq8;
    end
    sb.push_back(e);
  end

  // Monitor: compare outputs on the falling edge against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("q1",    {63'b0, q1},  {63'b0, e.q1});
      check("qbar1", {63'b0, qb1}, {63'b0, ~e.q1});
      check("chg1",  {63'b0, c1},  {63'b0, e.c1});
      check("q8",    {56'b0, q8},  {56'b0, e.q8});
      check("qbar8", {56'b0, qb8}, {56'b0, ~e.q8});
      check("chg8",  {63'b0, c8},  {63'b0, e.c8});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    d1 = 1'b1; en1 = 1'b1; d8 = 8'hFF; en8 = 1'b1;
    repeat (2) step();
    check("rst_q1",   {63'b0, q1},  64'd0);
    check("rst_qb1",  {63'b0, qb1}, 64'd1);
    check("rst_chg1", {63'b0, c1},  64'd0);
    check("rst_q8",   {56'b0, q8},  64'hA5);
    check("rst_qb8",  {56'b0, qb8}, 64'h5A);

    rst_n = 1'b1; d1 = 1'b0; d8 = 8'h3C;
    step();
    d1 = 1'b1;
    step();
    d1 = 1'b0;
    repeat (STAGES + 1) step();
    en1 = 1'b0; en8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d1 = i[0]; d8 = 8'(i * 37);
      step();
    end
    d1 = 1'b1;
    repeat (2) step();
    en1 = 1'b1;
    repeat (STAGES + 2) step();

    #2 rst_n = 1'b0;
    #1;
    check("async_q1",  {63'b0, q1},  64'd0);
    check("async_qb1", {63'b0, qb1}, 64'd1);
    check("async_q8",  {56'b0, q8},  64'hA5);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      d1  = 1'($urandom);
      en1 = ($urandom_range(0, 3) != 0);
      d8  = 8'($urandom);
      en8 = ($urandom_range(0, 2) != 0);
      if (i % 10 < 4) d8 = q8;
      rst_n = ($urandom_range(0, 39) != 0);
      step();
    end
    rst_n = 1'b1;
    repeat (3) step();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
